seg_display_ctrl: RTL and testbench
===================================

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NDIGITS, default 8: number of seven-segment digits driven, legal range 1..8.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, legal range >= 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port load, input, 1 bit: strobe; when high at a clk edge, capture all data inputs.
REQ-006 SHALL have port value, input, 4*NDIGITS bits: hex nibble per digit; nibble i drives digit i, digit 0 least significant.
REQ-007 SHALL have port dp, input, NDIGITS bits: per-digit decimal-point request, 1 = lit.
REQ-008 SHALL have port en, input, NDIGITS bits: per-digit enable, 0 = digit fully dark.
REQ-009 SHALL have port blink, input, NDIGITS bits: per-digit blink request.
REQ-010 SHALL have port lzb, input, 1 bit: leading-zero-blanking mode.
REQ-011 SHALL have port seg_out, output, 8*NDIGITS bits: byte i drives digit i, active-low, bit 7 = dp, bits 6:0 = g..a.
REQ-012 SHALL have port blink_phase, output, 1 bit: current blink phase, 1 = blinking digits dark.

Function
REQ-013 SHALL latch value, dp, en, blink and lzb into shadow registers at any clk edge where load = 1; inputs are ignored otherwise.
REQ-014 SHALL register seg_out from the shadow registers, giving 2-cycle latency from the load edge to a visible seg_out change.
REQ-015 SHALL decode nibbles to standard hex glyphs (0-9, A, b, C, d, E, F) with bit 0 = segment a; required glyphs include 0 -> 8'hC0, 1 -> 8'hF9, 8 -> 8'h80, F -> 8'h8E (dp off).
REQ-016 SHALL drive bit 7 of a byte low only when the shadow dp bit is 1 and the digit is not dark under REQ-017 or REQ-018.
REQ-017 SHALL drive byte i to 8'hFF when shadow en[i] = 0.
REQ-018 SHALL drive byte i to 8'hFF when shadow blink[i] = 1 and blink_phase = 1.
REQ-019 SHALL, when shadow lzb = 1, blank segments 6:0 (drive them high) of each enabled digit whose nibble is 0 and whose more-significant enabled digits are all blanked zeros; dp is unaffected.
REQ-020 SHALL never apply leading-zero blanking to digit 0; value 0 with lzb = 1 shows a single "0".
REQ-021 SHALL skip disabled digits when evaluating leading zeros; they neither stop nor start the blanking run.
REQ-022 SHALL run a blink counter from 0 to BLINK_DIV-1, then wrap to 0 and toggle blink_phase on the wrap cycle.
REQ-023 SHALL clear the blink counter to 0 and blink_phase to 0 on any load edge, so a fresh load is always visible first.
REQ-024 SHALL run the blink counter continuously, even when no blink bit is set.
REQ-025 SHALL have the REQ-023 clear take precedence over a wrap toggle in the same cycle.
REQ-026 SHALL accept back-to-back loads, each capturing its own cycle's inputs with no loss.

Reset
REQ-027 SHALL, while rst = 0, immediately force seg_out to all 8'hFF, blink_phase to 0, the blink counter to 0, and all shadow registers to 0.
REQ-028 SHALL abandon a load in flight when rst is asserted mid-operation, leaving all outputs dark until the first load after release.
REQ-029 SHALL resume counting on the first clk edge after rst deasserts.

Verification (NDIGITS = 8, BLINK_DIV = 4)
REQ-030 SHALL cover: reset, then load value = 32'h0123ABCF, en = 8'hFF, others 0 -> two cycles later bytes 7..0 = C0, F9, A4, B0, 88, 83, C6, 8E.
REQ-031 SHALL cover: load value = 32'h00000500, en = 8'hFF, lzb = 1 -> bytes 7..3 = FF, byte 2 = 92, bytes 1..0 = C0; then value = 0 -> bytes 7..1 = FF, byte 0 = C0.
REQ-032 SHALL cover: load blink = 8'h01, value = 0 -> byte 0 = C0 for 4 cycles, FF for 4 cycles, with blink_phase toggling at each wrap; a reload mid-dark restores C0 within 2 cycles.
REQ-033 SHALL cover: load en = 8'hFE, dp = 8'h03, value = 0 -> byte 0 = FF, byte 1 = 40.
REQ-034 SHALL cover: assert rst asynchronously between clk edges while digits are lit -> seg_out = all FF before the next edge, and stays FF after release until a load.
REQ-035 SHALL cover: load pulses on consecutive cycles with value = 1 then 2 -> byte 0 shows F9 then A4, each on its own cycle.

Source files
------------

// File: rtl/seg_display_ctrl_if.sv
// Bus bundle for seg_display_ctrl.
//   master: drives load/value/dp/en/blink/lzb, observes seg_out/blink_phase
//   slave : the display controller side
interface seg_display_ctrl_if #(
  parameter int unsigned NDIGITS = 8
);
  logic                   load;
  logic [4*NDIGITS-1:0]   value;
  logic [NDIGITS-1:0]     dp;
  logic [NDIGITS-1:0]     en;
  logic [NDIGITS-1:0]     blink;
  logic                   lzb;
  logic [8*NDIGITS-1:0]   seg_out;
  logic                   blink_phase;

  modport master (
    output load, value, dp, en, blink, lzb,
    input  seg_out, blink_phase
  );

  modport slave (
    input  load, value, dp, en, blink, lzb,
    output seg_out, blink_phase
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment display controller.
// Captures digit data on a load strobe into shadow registers and drives
// registered active-low segment bytes (bit 7 = dp, bits 6:0 = g..a) with
// per-digit enable, blink and optional leading-zero blanking.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   bus (slave) : load/value/dp/en/blink/lzb in, seg_out/blink_phase out
module seg_display_ctrl #(
  parameter int unsigned NDIGITS   = 8,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  seg_display_ctrl_if.slave  bus
);

  localparam int unsigned CW      = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*NDIGITS-1:0] val_q;
  logic [NDIGITS-1:0]   dp_q;
  logic [NDIGITS-1:0]   en_q;
  logic [NDIGITS-1:0]   blink_q;
  logic                 lzb_q;

  logic [CW-1:0]        cnt_q;
  logic                 phase_q;
  logic [8*NDIGITS-1:0] seg_q;
  logic [8*NDIGITS-1:0] seg_c;

  // Hex nibble to active-low a..g pattern (bit 0 = a)
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Shadow registers, written only on a load strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q   <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      blink_q <= '0;
      lzb_q   <= 1'b0;
    end else if (bus.load) begin
      val_q   <= bus.value;
      dp_q    <= bus.dp;
      en_q    <= bus.en;
      blink_q <= bus.blink;
      lzb_q   <= bus.lzb;
    end
  end

  // Free-running blink timer; a load restarts it so new data shows lit first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Segment byte generation; scan from the most significant digit so the
  // leading-zero run ends at the first enabled digit that is shown.
  always_comb begin : seg_gen
    logic       run;
    logic [3:0] nib;
    logic [6:0] segs;
    seg_c = '1;
    run   = 1'b1;
    nib   = '0;
    segs  = '1;
    for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
      nib  = val_q[4*i +: 4];
      segs = decode(nib);
      if (en_q[i]) begin
        // disabled digits never touch the run
        if (lzb_q && run && (i != 0) && (nib == 4'h0)) begin
          segs = '1;
        end else begin
          run = 1'b0;
        end
        if (!(blink_q[i] && phase_q)) begin
          seg_c[8*i +: 8] = {~dp_q[i], segs};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_c;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.blink_phase = phase_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl (NDIGITS = 8, BLINK_DIV = 4).
module tb_seg_display_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned BD = 4;

  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic clk;
  logic rst;
  logic mon_on;
  int   passed;
  int   total;

  seg_display_ctrl_if #(.NDIGITS(ND)) bus ();

  seg_display_ctrl #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_val;
  logic [7:0]  m_dp, m_en, m_blink;
  logic        m_lzb;
  int          m_tick;   // edges since last load or reset
  logic [63:0] m_seg;

  function automatic logic phase_of(input int tick);
    return ((tick / BD) % 2) == 1;
  endfunction

  function automatic logic [63:0] disp(input logic [31:0] val, input logic [7:0] dp,
                                       input logic [7:0] en, input logic [7:0] bl,
                                       input logic lzb, input logic ph);
    logic [63:0] r;
    logic [7:0]  g;
    logic [3:0]  nib;
    logic        shown_above;
    r = '1;
    for (int i = 0; i < 8; i++) begin
      nib = val[4*i +: 4];
      shown_above = 1'b0;
      for (int j = i + 1; j < 8; j++)
        if (en[j] && val[4*j +: 4] != 4'h0) shown_above = 1'b1;
      if (en[i] && !(bl[i] && ph)) begin
        g = GLYPH[nib];
        if (lzb && i > 0 && nib == 4'h0 && !shown_above) g = 8'hFF;
        g[7] = ~dp[i];
        r[8*i +: 8] = g;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val <= '0; m_dp <= '0; m_en <= '0; m_blink <= '0; m_lzb <= 1'b0;
      m_tick <= 0;
      m_seg <= '1;
    end else begin
      m_seg <= disp(m_val, m_dp, m_en, m_blink, m_lzb, phase_of(m_tick));
      if (bus.load) begin
        m_val <= bus.value; m_dp <= bus.dp; m_en <= bus.en;
        m_blink <= bus.blink; m_lzb <= bus.lzb;
        m_tick <= 0;
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_on) begin
      check("model_seg", bus.seg_out, m_seg);
      check("model_phase", 64'(bus.blink_phase), 64'(phase_of(m_tick)));
    end
  end

  task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e,
                         input logic [7:0] b, input logic z);
    @(negedge clk);
    bus.value = v; bus.dp = d; bus.en = e; bus.blink = b; bus.lzb = z;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    passed = 0; total = 0; mon_on = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.en = '0;
    bus.blink = '0; bus.lzb = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1 mon_on = 1'b1;
    check("reset_seg", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("reset_phase", 64'(bus.blink_phase), 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("dark_after_reset", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFFF);

    // hex glyphs
    do_load(32'h0123_ABCF, 8'h00, 8'hFF, 8'h00, 1'b0);
    check("hex_glyphs", bus.seg_out, 64'hC0F9_A4B0_8883_C68E);

    // leading-zero blanking
    do_load(32'h0000_0500, 8'h00, 8'hFF, 8'h00, 1'b1);
    check("lzb_500", bus.seg_out, 64'hFFFF_FFFF_FF92_C0C0);
    do_load(32'h0000_0000, 8'h00, 8'hFF, 8'h00, 1'b1);
    check("lzb_zero", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFC0);
    do_load(32'h0000_0300, 8'h00, 8'hF7, 8'h00, 1'b1);
    check("lzb_dis_zero", bus.seg_out, 64'hFFFF_FFFF_FFB0_C0C0);
    do_load(32'h0000_9000, 8'h00, 8'hF7, 8'h00, 1'b1);
    check("lzb_dis_nonzero", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFC0);

    // blink: 4 cycles lit, then dark; reload while dark
    do_load(32'h0000_0000, 8'h00, 8'hFF, 8'h01, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("blink_byte0", 64'(bus.seg_out[7:0]), (k < 4) ? 64'hC0 : 64'hFF);
      if (k == 4) check("blink_phase_hi", 64'(bus.blink_phase), 64'h1);
      @(negedge clk);
    end
    do_load(32'h0000_0000, 8'h00, 8'hFF, 8'h01, 1'b0);
    check("reload_lit", 64'(bus.seg_out[7:0]), 64'hC0);
    check("reload_phase", 64'(bus.blink_phase), 64'h0);

    // enable / decimal point
    do_load(32'h0000_0000, 8'h03, 8'hFE, 8'h00, 1'b0);
    check("en_dp", bus.seg_out, 64'hC0C0_C0C0_C0C0_40FF);

    // back-to-back loads
    @(negedge clk);
    bus.value = 32'h1; bus.dp = '0; bus.en = 8'hFF; bus.blink = '0; bus.lzb = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.value = 32'h2;
    @(negedge clk);
    bus.load = 1'b0;
    check("b2b_first", 64'(bus.seg_out[7:0]), 64'hF9);
    @(negedge clk);
    check("b2b_second", 64'(bus.seg_out[7:0]), 64'hA4);

    // asynchronous reset between edges
    do_load(32'h8888_8888, 8'hFF, 8'hFF, 8'h00, 1'b0);
    check("lit_before_rst", bus.seg_out, 64'h0000_0000_0000_0000);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst_seg", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("async_rst_phase", 64'(bus.blink_phase), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("dark_after_release", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
    do_load(32'h0000_0001, 8'h00, 8'h01, 8'h00, 1'b0);
    check("load_after_release", bus.seg_out, 64'hFFFF_FFFF_FFFF_FFF9);

    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
